move_uart_tx: RTL and testbench
===============================

# move_uart_tx

Serialises each move committed by the game state machine onto the UART link to the opponent board. It sits directly downstream of the game FSM: it consumes the FSM's one-cycle `tx_ready` strobe and its `move` byte, and emits a framed 8N1 packet on `tx_out`. Move bytes are opaque to this block: row in [7:4], column in [3:0], and 0xFF means pass. No validation is done here.

## Interface
- `CLKS_PER_BIT`, default 564: clock cycles per UART bit (65 MHz / 115200). Legal range is 2..1023.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.

- `clk_in` input 1: system clock.
- `rst_in_n` input 1: reset, asynchronous, active-low.
- `tx_ready` input 1: one-cycle strobe from the game FSM requesting transmission of `move`.
- `move` input 8: move byte. Sampled only on the accepting edge.
- `tx_out` output 1: UART line. Idles high.
- `busy` output 1: high while a packet is in flight.
- `frame_done` output 1: one-cycle pulse when the last stop bit completes.
- `overrun` output 1: sticky flag, set when `tx_ready` arrives while busy. Cleared only by reset.

## Operation
- Reset values: `tx_out`=1, `busy`=0, `frame_done`=0, `overrun`=0. The internal state is IDLE, all counters are 0 and the latched move is 0.
- Packet format: `SYNC_BYTE`, then the move byte, then a checksum byte if configured.
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1). That is 10 bits per byte, each held for exactly `CLKS_PER_BIT` cycles.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE → START on `tx_ready`=1. On that edge the block latches `move`, loads byte index 0, sets `busy`=1 and drives `tx_out`=0.
- START → DATA after `CLKS_PER_BIT` cycles, with bit index 0.
- DATA walks bit index 0..7 and moves to STOP after bit 7 has been held for its full period.
- At the end of STOP:
  - If more bytes remain, increment the byte index and go to START.
  - Otherwise go to IDLE, set `busy`=0 and pulse `frame_done`.
- The baud counter is 10 bits. It counts from 0 to `CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
- `tx_ready` while `busy`=1 is dropped. The in-flight packet is unaffected and `overrun` is set to 1.
- `tx_ready` in the cycle where `frame_done`=1: `busy` is already 0, so the request is accepted normally with no overrun.
- Changes on `move` after the accepting edge have no effect on the current packet.
- Asserting reset mid-packet forces `tx_out`=1 immediately (asynchronously) and abandons the packet. After release the block is in IDLE and no `frame_done` is emitted for the abandoned packet.

## Timing
- Let E be the edge that samples `tx_ready`=1 in IDLE.
- `tx_out` falls and `busy` rises, both registered, immediately after E.
- The first start bit spans `CLKS_PER_BIT` cycles starting at E.
- Let B be the number of bytes in a packet: 3 with checksum, 2 without.
- `busy` stays high for exactly B·10·`CLKS_PER_BIT` cycles.
- `frame_done` is high for the single cycle following the last stop-bit period. It coincides with the first cycle of `busy`=0.
- The minimum gap between accepted requests is B·10·`CLKS_PER_BIT` cycles.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `MOVE_TX_CHECKSUM_EN`.
- Defined: a third byte is appended, equal to `SYNC_BYTE` ^ move. Packets are 30 bit periods long.
- Undefined: no checksum byte is sent. Packets are 20 bit periods long and the byte-index compare stops at 1.

## Test plan
Tests use `CLKS_PER_BIT`=4.
- Idle and reset: hold reset for 3 cycles, then release → `tx_out`=1, `busy`=0, `overrun`=0, `frame_done`=0, and all stay there for 100 cycles with no strobe.
- Single move, checksum enabled: pulse `tx_ready` with `move`=8'h34 → decoded bytes are A5, 34, 91. `busy` is high for 120 cycles and `frame_done` pulses once on cycle 121 after E. Checksum disabled: bytes A5, 34, `busy` high for 80 cycles.
- Pass move: `move`=8'hFF → second byte is FF, checksum is 5A. All stop bits are 1 and all start bits are 0.
- Overrun: a second strobe 10 cycles after the first, with `move`=8'h00 → the packet still carries 34, `overrun`=1 and stays 1 after `frame_done`. No second packet is sent.
- Back-to-back: strobe `move`=8'h12 in the `frame_done` cycle → a new packet A5, 12, B7 begins on the next cycle, and `overrun` stays 0.
- Reset mid-packet: assert `rst_in_n`=0 during the DATA bits of byte 1 → `tx_out`=1 in the same cycle. After release, a strobe with 8'h56 produces a clean A5, 56, F3.

Source files
------------

// File: rtl/move_uart_tx.sv
// move_uart_tx: frames each committed game move as an 8N1 packet to the
// opponent board. Packet = SYNC_BYTE, move byte, and optionally a checksum
// byte (SYNC_BYTE ^ move) when MOVE_TX_CHECKSUM_EN is defined.
//
// Ports:
//   clk_in      system clock
//   rst_in_n    asynchronous active-low reset
//   tx_ready    one-cycle request strobe from the game FSM
//   move        move byte, sampled only on the accepting edge
//   tx_out      UART line, idles high (registered)
//   busy        packet in flight (registered)
//   frame_done  one-cycle pulse after the last stop bit (registered)
//   overrun     sticky: request seen while busy, cleared only by reset
module move_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 564,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       tx_ready,
  input  logic [7:0] move,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned BAUD_W = 10;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef MOVE_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [1:0]        r_byte, w_byte_nxt;
  logic [7:0]        r_move, w_move_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ovr, w_ovr_nxt;
  logic [7:0]        w_cur_byte;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Byte currently on the wire, selected by byte index
  always_comb begin
    w_cur_byte = SYNC_BYTE;
    case (r_byte)
      2'd0:    w_cur_byte = SYNC_BYTE;
      2'd1:    w_cur_byte = r_move;
      default: w_cur_byte = SYNC_BYTE ^ r_move;
    endcase
  end

  // State register plus registered outputs
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_move  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_move  <= w_move_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and next-output logic; line value is computed one cycle
  // ahead so tx_out changes exactly on each bit boundary
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_move_nxt  = r_move;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;

    unique case (r_state)
      IDLE: begin
        if (tx_ready) begin
          w_state_nxt = START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_move_nxt  = move;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = w_cur_byte[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = w_cur_byte[3'(r_bit + 3'd1)];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_byte == LAST_BYTE) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = 1'b1;
          end else begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Requests during a packet are dropped but remembered
    if ((r_state != IDLE) && tx_ready) begin
      w_ovr_nxt = 1'b1;
    end
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_move_uart_tx.sv
// Directed bench for move_uart_tx with CLKS_PER_BIT=4. Decodes the line at
// mid-bit and checks bytes, framing, busy length, frame_done and overrun.
module tb_move_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef MOVE_TX_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif
  localparam int NCYC = NBYTES * 10 * CPB;

  logic       clk_in;
  logic       rst_in_n;
  logic       tx_ready;
  logic [7:0] move;
  logic       tx_out;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  move_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk_in     (clk_in),
    .rst_in_n   (rst_in_n),
    .tx_ready   (tx_ready),
    .move       (move),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Optionally strobe, then watch one whole packet. Cycle c is sampled at
  // the c-th negedge after the accepting edge E. If chain is set, a new
  // strobe is raised in the frame_done cycle.
  task automatic capture(input bit do_strobe, input logic [7:0] m,
                         input int ovr_cyc, input bit exp_ovr,
                         input bit chain, input logic [7:0] chain_m);
    logic [9:0] frames [3];
    int busy_cnt, done_cnt, bad_frame;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA5;
    exp_b[1] = m;
    exp_b[2] = 8'hA5 ^ m;
    busy_cnt = 0;
    done_cnt = 0;
    bad_frame = 0;
    for (int f = 0; f < 3; f++) frames[f] = '0;
    if (do_strobe) begin
      @(negedge clk_in);
      tx_ready = 1'b1;
      move = m;
    end
    for (int c = 1; c <= NCYC + 1; c++) begin
      @(negedge clk_in);
      tx_ready = 1'b0;
      move = 8'h00;
      if (c == 1) begin
        check("tx_falls_after_E", 32'(tx_out), 32'd0);
        check("busy_rises_after_E", 32'(busy), 32'd1);
      end
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
      if (c <= NCYC && (c % CPB) == 2) begin
        frames[(c / CPB) / 10][(c / CPB) % 10] = tx_out;
      end
      if (c == ovr_cyc) begin
        tx_ready = 1'b1;
        move = 8'h00;
      end
      if (c == NCYC + 1) begin
        check("frame_done_cycle", 32'(frame_done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("overrun_at_done", 32'(overrun), 32'(exp_ovr));
        if (chain) begin
          tx_ready = 1'b1;
          move = chain_m;
        end
      end
    end
    for (int f = 0; f < NBYTES; f++) begin
      if (frames[f][0] !== 1'b0 || frames[f][9] !== 1'b1) bad_frame++;
      check($sformatf("byte%0d", f), 32'(frames[f][8:1]), 32'(exp_b[f]));
    end
    check("start_stop_bits", 32'(bad_frame), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(NCYC));
    check("frame_done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int dev;
    tx_ready = 1'b0;
    move = 8'h00;
    rst_in_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in_n = 1'b1;

    // Idle after reset
    @(negedge clk_in);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    dev = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0 || frame_done !== 1'b0) dev++;
    end
    check("idle_stable", 32'(dev), 32'd0);

    // Pass move
    capture(1'b1, 8'hFF, 0, 1'b0, 1'b0, 8'h00);
    repeat (5) @(negedge clk_in);

    // Single move chained back-to-back into 0x12 on the frame_done cycle
    capture(1'b1, 8'h34, 0, 1'b0, 1'b1, 8'h12);
    capture(1'b0, 8'h12, 0, 1'b0, 1'b0, 8'h00);
    repeat (5) @(negedge clk_in);

    // Overrun: second strobe 10 cycles in is dropped
    capture(1'b1, 8'h34, 10, 1'b1, 1'b0, 8'h00);
    dev = 0;
    repeat (60) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1 || busy !== 1'b0) dev++;
    end
    check("no_second_packet", 32'(dev), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during byte-1 data bits (move 0x00 keeps the line low there)
    @(negedge clk_in);
    tx_ready = 1'b1;
    move = 8'h00;
    @(negedge clk_in);
    tx_ready = 1'b0;
    repeat (52) @(negedge clk_in);
    check("line_low_before_rst", 32'(tx_out), 32'd0);
    rst_in_n = 1'b0;
    #1;
    check("async_rst_tx_out", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    dev = 0;
    repeat (4 * NCYC) begin
      @(negedge clk_in);
      if (frame_done !== 1'b0 || busy !== 1'b0) dev++;
    end
    check("abandoned_quiet", 32'(dev), 32'd0);
    capture(1'b1, 8'h56, 0, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
